// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the EX/ID pipeline stages and the multiply/divide unit.
// The pipeline side is the master; the MDU is the slave.
interface mdu_ctrl_if;
  logic        start_EX;
  logic [2:0]  op_EX;
  logic [31:0] a_EX;
  logic [31:0] b_EX;
  logic        flush;
  logic        mdUse_ID;
  logic        busy;
  logic        stall_ID;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start_EX, op_EX, a_EX, b_EX, flush, mdUse_ID,
    input  busy, stall_ID, hi, lo
  );

  modport slave (
    input  start_EX, op_EX, a_EX, b_EX, flush, mdUse_ID,
    output busy, stall_ID, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer and HI/LO owner. The result is computed at issue
// and held in pend_hi/pend_lo until the fixed busy window ends.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  mdu
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;
  logic [31:0]    pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic           acc;
  logic [63:0]    prod_s, prod_u;
  logic [31:0]    div_bs, div_bu;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]    quo_u, rem_u;

  assign acc = mdu.start_EX & ~mdu.flush & (state_q == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    prod_s = {{32{mdu.a_EX[31]}}, mdu.a_EX} * {{32{mdu.b_EX[31]}}, mdu.b_EX};
    prod_u = {32'b0, mdu.a_EX} * {32'b0, mdu.b_EX};

    // Dividing 0x80000000 by 1 instead of -1 yields exactly the required q=0x80000000, r=0.
    div_bs = ((mdu.b_EX == 32'd0) ||
              (mdu.a_EX == 32'h8000_0000 && mdu.b_EX == 32'hFFFF_FFFF)) ? 32'd1 : mdu.b_EX;
    div_bu = (mdu.b_EX == 32'd0) ? 32'd1 : mdu.b_EX;
    quo_s  = $signed(mdu.a_EX) / $signed(div_bs);
    rem_s  = $signed(mdu.a_EX) % $signed(div_bs);
    quo_u  = mdu.a_EX / div_bu;
    rem_u  = mdu.a_EX % div_bu;

    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    case (state_q)
      IDLE: begin
        if (acc) begin
          case (mdu.op_EX)
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = (mdu.op_EX == OP_MULT) ? prod_s : prod_u;
              cnt_d   = CW'(MUL_CYCLES);
              state_d = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor re-commits the current HI/LO, leaving them unchanged.
              if (mdu.b_EX == 32'd0) begin
                pend_hi_d = hi_q;
                pend_lo_d = lo_q;
              end else if (mdu.op_EX == OP_DIV) begin
                pend_hi_d = rem_s;
                pend_lo_d = quo_s;
              end else begin
                pend_hi_d = rem_u;
                pend_lo_d = quo_u;
              end
              cnt_d   = CW'(DIV_CYCLES);
              state_d = BUSY;
            end
            OP_MTHI: hi_d = mdu.a_EX;
            OP_MTLO: lo_d = mdu.a_EX;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The issue-cycle term keeps a dependent mfhi/mflo in ID before busy rises.
  always_comb begin
    mdu.busy     = (state_q == BUSY);
    mdu.stall_ID = mdu.mdUse_ID & ((state_q == BUSY) | (acc & ~mdu.op_EX[2]));
    mdu.hi       = hi_q;
    mdu.lo       = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed scoreboard bench for mdu_ctrl: expected HI/LO pairs are queued at issue
// and popped in the first cycle after the busy window.
module tb_mdu_ctrl;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hl_t;

  logic clk;
  logic reset;
  int   tests;
  int   failed;
  hl_t  sb_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mdu_ctrl_if bus ();

  mdu_ctrl #(
    .MUL_CYCLES (MUL_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one long op, walks the busy window and checks the committed HI/LO.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int n, input logic md_use, input int flush_at,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    hl_t got;
    bus.start_EX = 1'b1;
    bus.op_EX    = op;
    bus.a_EX     = a;
    bus.b_EX     = b;
    bus.mdUse_ID = md_use;
    sb_q.push_back('{hi: exp_hi, lo: exp_lo});
    @(negedge clk);
    check_output("c0_busy", 32'(bus.busy), 32'd0);
    check_output("c0_stall", 32'(bus.stall_ID), 32'(md_use));
    next_cycle();
    bus.start_EX = 1'b0;
    for (int i = 1; i <= n; i++) begin
      bus.flush = (i == flush_at);
      @(negedge clk);
      check_output("busy_win", 32'(bus.busy), 32'd1);
      check_output("stall_win", 32'(bus.stall_ID), 32'(md_use));
      if (i == n) begin
        check_output("hold_hi", bus.hi, model_hi);
        check_output("hold_lo", bus.lo, model_lo);
      end
      next_cycle();
    end
    bus.flush = 1'b0;
    @(negedge clk);
    check_output("done_busy", 32'(bus.busy), 32'd0);
    check_output("done_stall", 32'(bus.stall_ID), 32'd0);
    check_output("sb_size", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      got = sb_q.pop_front();
      check_output("commit_hi", bus.hi, got.hi);
      check_output("commit_lo", bus.lo, got.lo);
      model_hi = got.hi;
      model_lo = got.lo;
    end
    bus.mdUse_ID = 1'b0;
    next_cycle();
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    model_hi     = '0;
    model_lo     = '0;
    reset        = 1'b0;
    bus.start_EX = 1'b0;
    bus.op_EX    = 3'd0;
    bus.a_EX     = '0;
    bus.b_EX     = '0;
    bus.flush    = 1'b0;
    bus.mdUse_ID = 1'b0;
    #3;
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_stall", 32'(bus.stall_ID), 32'd0);
    check_output("rst_hi", bus.hi, 32'd0);
    check_output("rst_lo", bus.lo, 32'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    apply_stimulus(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, MUL_N, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    apply_stimulus(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, MUL_N, 1'b1, 0, 32'h0000_0001, 32'hFFFF_FFFE);
    apply_stimulus(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, DIV_N, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    apply_stimulus(3'd3, 32'h0000_0007, 32'h0000_0000, DIV_N, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    apply_stimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 1'b0, 0, 32'h0000_0000, 32'h8000_0000);

    // MTHI then MTLO back to back: each visible the cycle after issue, no busy.
    bus.start_EX = 1'b1;
    bus.op_EX    = 3'd4;
    bus.a_EX     = 32'h1234_5678;
    bus.mdUse_ID = 1'b1;
    @(negedge clk);
    check_output("mthi_busy", 32'(bus.busy), 32'd0);
    check_output("mthi_stall", 32'(bus.stall_ID), 32'd0);
    next_cycle();
    bus.op_EX = 3'd5;
    bus.a_EX  = 32'h9ABC_DEF0;
    @(negedge clk);
    check_output("mthi_hi", bus.hi, 32'h1234_5678);
    check_output("mtlo_busy", 32'(bus.busy), 32'd0);
    next_cycle();
    bus.start_EX = 1'b0;
    bus.mdUse_ID = 1'b0;
    @(negedge clk);
    check_output("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    check_output("mtlo_hi", bus.hi, 32'h1234_5678);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;
    next_cycle();

    // Flushed issue must be squashed entirely.
    bus.start_EX = 1'b1;
    bus.op_EX    = 3'd0;
    bus.a_EX     = 32'd3;
    bus.b_EX     = 32'd3;
    bus.flush    = 1'b1;
    bus.mdUse_ID = 1'b1;
    @(negedge clk);
    check_output("flush_stall", 32'(bus.stall_ID), 32'd0);
    next_cycle();
    bus.start_EX = 1'b0;
    bus.flush    = 1'b0;
    bus.mdUse_ID = 1'b0;
    @(negedge clk);
    check_output("flush_busy", 32'(bus.busy), 32'd0);
    check_output("flush_hi", bus.hi, model_hi);
    check_output("flush_lo", bus.lo, model_lo);
    next_cycle();

    apply_stimulus(3'd2, 32'd100, 32'd7, DIV_N, 1'b1, 3, 32'd2, 32'd14);

    // Asynchronous reset in busy cycle 2 of a DIV discards the pending result.
    bus.start_EX = 1'b1;
    bus.op_EX    = 3'd2;
    bus.a_EX     = 32'd50;
    bus.b_EX     = 32'd3;
    bus.mdUse_ID = 1'b1;
    next_cycle();
    bus.start_EX = 1'b0;
    next_cycle();
    @(negedge clk);
    check_output("pre_rst_busy", 32'(bus.busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_output("arst_busy", 32'(bus.busy), 32'd0);
    check_output("arst_stall", 32'(bus.stall_ID), 32'd0);
    check_output("arst_hi", bus.hi, 32'd0);
    check_output("arst_lo", bus.lo, 32'd0);
    model_hi     = '0;
    model_lo     = '0;
    bus.mdUse_ID = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();

    apply_stimulus(3'd0, 32'd3, 32'd4, MUL_N, 1'b1, 0, 32'd0, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
